// File: rtl/id_stage.sv
// Instruction decode stage: field decode, 32-entry register file with
// same-cycle write bypass, load-use hazard detection and the ID_EX register.
module id_stage #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*SIZE-1:0] IF_ID,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [SIZE-1:0]   wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [SIZE-1:0]   id_pc_next,
  output logic [SIZE-1:0]   id_rs_data,
  output logic [SIZE-1:0]   id_rt_data,
  output logic [SIZE-1:0]   id_imm,
  output logic [4:0]        id_dest,
  output logic [5:0]        id_funct,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_alu_src,
  output logic              id_branch,
  output logic              id_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [SIZE-1:0] instr;
  logic [SIZE-1:0] pc_next;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [SIZE-1:0] imm_ext;

  assign instr   = IF_ID[SIZE-1:0];
  assign pc_next = IF_ID[2*SIZE-1:SIZE];
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm_ext = {{(SIZE-16){instr[15]}}, instr[15:0]};

  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic       dec_branch;
  logic       dec_illegal;
  logic       dec_uses_rt;
  logic [4:0] dec_dest;

  // Opcode to control decode; unknown opcodes become a flagged NOP
  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    dec_uses_rt   = 1'b0;
    dec_dest      = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        dec_uses_rt   = 1'b1;
        dec_dest      = rd;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_dest      = rt;
      end
      OP_LW: begin
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_dest      = rt;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        dec_branch    = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [SIZE-1:0] rf [32];
  logic            wb_live;

  // r0 is never written, so it stays at its reset value of zero
  assign wb_live = wb_en && (wb_addr != 5'd0);

  // Register file write port, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[wb_addr] <= wb_data;
    end
  end

  logic [SIZE-1:0] rs_data;
  logic [SIZE-1:0] rt_data;

  // Read ports with writeback bypass so a same-cycle write is observed
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) rs_data = (wb_live && wb_addr == rs) ? wb_data : rf[rs];
    if (rt != 5'd0) rt_data = (wb_live && wb_addr == rt) ? wb_data : rf[rt];
  end

  logic hazard_src;
  logic bubble;

  assign hazard_src = (id_dest == rs) || (dec_uses_rt && (id_dest == rt));
  assign stall = if_valid && id_valid && id_mem_read && (id_dest != 5'd0)
                 && !flush && hazard_src;
  assign bubble = flush || stall || !if_valid;

  // ID_EX register; a bubble clears valid and all controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_pc_next   <= '0;
      id_rs_data   <= '0;
      id_rt_data   <= '0;
      id_imm       <= '0;
      id_dest      <= 5'd0;
      id_funct     <= 6'd0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_alu_src   <= 1'b0;
      id_branch    <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      id_valid     <= !bubble;
      id_pc_next   <= pc_next;
      id_rs_data   <= rs_data;
      id_rt_data   <= rt_data;
      id_imm       <= imm_ext;
      id_dest      <= bubble ? 5'd0 : dec_dest;
      id_funct     <= instr[5:0];
      id_reg_write <= !bubble && dec_reg_write;
      id_mem_read  <= !bubble && dec_mem_read;
      id_mem_write <= !bubble && dec_mem_write;
      id_alu_src   <= !bubble && dec_alu_src;
      id_branch    <= !bubble && dec_branch;
      id_illegal   <= !bubble && dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage: table of per-cycle stimulus with
// hand-computed stall and ID_EX expectations, plus reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] IF_ID;
  logic        if_valid, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, id_valid;
  logic [31:0] id_pc_next, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_dest;
  logic [5:0]  id_funct;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_illegal;

  id_stage #(.SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .if_valid(if_valid), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .id_pc_next(id_pc_next), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_dest(id_dest), .id_funct(id_funct),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // control bundle order: {reg_write, mem_read, mem_write, alu_src, branch, illegal}
  localparam logic [5:0] C_R   = 6'b100000;
  localparam logic [5:0] C_AI  = 6'b100100;
  localparam logic [5:0] C_LW  = 6'b110100;
  localparam logic [5:0] C_SW  = 6'b001100;
  localparam logic [5:0] C_BQ  = 6'b000010;
  localparam logic [5:0] C_ILL = 6'b000001;
  localparam logic [5:0] C_NO  = 6'b000000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        v, fl, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_stall, e_valid;
    logic [5:0]  e_ctl;
    logic [4:0]  e_dest;
    logic [31:0] e_rs, e_rt, e_imm;
    logic        chk_data;
  } vec_t;

  vec_t vecs[18];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, pc, input logic v, fl, we,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic es, ev, input logic [5:0] ectl,
                              input logic [4:0] edest, input logic [31:0] ers, ert, eimm,
                              input logic cd);
    vec_t r;
    r.instr = instr; r.pc = pc; r.v = v; r.fl = fl; r.we = we; r.wa = wa; r.wd = wd;
    r.e_stall = es; r.e_valid = ev; r.e_ctl = ectl; r.e_dest = edest;
    r.e_rs = ers; r.e_rt = ert; r.e_imm = eimm; r.chk_data = cd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [5:0] ctl_now();
    return {id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_illegal};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // stimulus table: instr, pc, if_valid, flush, wb_en, wb_addr, wb_data,
    //                 stall, valid, ctl, dest, rs_data, rt_data, imm, check data
    vecs[0]  = mk(rtype(3,3,5,6'h20), 6, 1,0, 1,3,32'hDEAD, 0,1,C_R,5, 32'hDEAD,32'hDEAD,32'h2820,1);
    vecs[1]  = mk(rtype(0,3,4,6'h20), 7, 1,0, 1,0,32'h1234, 0,1,C_R,4, 0,32'hDEAD,32'h2020,1);
    vecs[2]  = mk(rtype(0,0,0,6'h20), 8, 1,0, 0,0,0,        0,1,C_R,0, 0,0,32'h0020,1);
    vecs[3]  = mk(itype(6'h23,3,2,16'h8), 9, 1,0, 0,0,0,    0,1,C_LW,2, 32'hDEAD,0,32'h8,1);
    vecs[4]  = mk(rtype(2,0,6,6'h20), 10, 1,0, 0,0,0,       1,0,C_NO,0, 0,0,0,0);
    vecs[5]  = mk(rtype(2,0,6,6'h20), 10, 1,0, 0,0,0,       0,1,C_R,6, 0,0,32'h3020,1);
    vecs[6]  = mk(itype(6'h23,3,2,16'h8), 11, 1,0, 0,0,0,   0,1,C_LW,2, 32'hDEAD,0,32'h8,1);
    vecs[7]  = mk(itype(6'h08,4,2,16'h1), 12, 1,0, 1,4,32'h55, 0,1,C_AI,2, 32'h55,0,32'h1,1);
    vecs[8]  = mk(itype(6'h23,1,0,16'h0), 13, 1,0, 0,0,0,   0,1,C_LW,0, 0,0,0,1);
    vecs[9]  = mk(rtype(0,0,7,6'h20), 14, 1,0, 0,0,0,       0,1,C_R,7, 0,0,32'h3820,1);
    vecs[10] = mk(itype(6'h23,3,2,16'h8), 15, 1,0, 0,0,0,   0,1,C_LW,2, 32'hDEAD,0,32'h8,1);
    vecs[11] = mk(itype(6'h2B,5,2,16'h0), 16, 1,1, 0,0,0,   0,0,C_NO,0, 0,0,0,0);
    vecs[12] = mk(itype(6'h04,3,3,16'hFFFF), 17, 0,0, 0,0,0, 0,0,C_NO,0, 0,0,0,0);
    vecs[13] = mk(itype(6'h04,3,3,16'hFFFF), 17, 1,0, 0,0,0, 0,1,C_BQ,0, 32'hDEAD,32'hDEAD,32'hFFFFFFFF,1);
    vecs[14] = mk(itype(6'h3F,4,0,16'h1234), 18, 1,0, 0,0,0, 0,1,C_ILL,0, 32'h55,0,32'h1234,1);
    vecs[15] = mk(itype(6'h23,3,2,16'h8), 19, 1,0, 0,0,0,   0,1,C_LW,2, 32'hDEAD,0,32'h8,1);
    vecs[16] = mk(itype(6'h2B,0,2,16'h4), 20, 1,0, 0,0,0,   1,0,C_NO,0, 0,0,0,0);
    vecs[17] = mk(itype(6'h2B,0,2,16'h4), 20, 1,0, 0,0,0,   0,1,C_SW,0, 0,0,32'h4,1);

    // reset held with a valid ADDI r1,r0,-3 on the input
    rst_n = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0;
    IF_ID = {32'h5, itype(6'h08,0,1,16'hFFFD)}; if_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid", {31'd0, id_valid}, 0);
    chk("rst stall", {31'd0, stall}, 0);
    chk("rst ctl", {26'd0, ctl_now()}, 0);
    chk("rst dest", {27'd0, id_dest}, 0);
    chk("rst pc", id_pc_next, 0);
    chk("rst imm", id_imm, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("addi valid", {31'd0, id_valid}, 1);
    chk("addi pc", id_pc_next, 32'h5);
    chk("addi imm", id_imm, 32'hFFFFFFFD);
    chk("addi dest", {27'd0, id_dest}, 1);
    chk("addi ctl", {26'd0, ctl_now()}, {26'd0, C_AI});

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      IF_ID = {vecs[i].pc, vecs[i].instr};
      if_valid = vecs[i].v; flush = vecs[i].fl;
      wb_en = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d ctl", i), {26'd0, ctl_now()}, {26'd0, vecs[i].e_ctl});
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d dest", i), {27'd0, id_dest}, {27'd0, vecs[i].e_dest});
        chk($sformatf("v%0d rs", i), id_rs_data, vecs[i].e_rs);
        chk($sformatf("v%0d rt", i), id_rt_data, vecs[i].e_rt);
        chk($sformatf("v%0d imm", i), id_imm, vecs[i].e_imm);
        chk($sformatf("v%0d pc", i), id_pc_next, vecs[i].pc);
        chk($sformatf("v%0d funct", i), {26'd0, id_funct}, {26'd0, vecs[i].instr[5:0]});
      end
    end

    // asynchronous reset in the middle of a cycle clears outputs at once
    wb_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", {31'd0, id_valid}, 0);
    chk("midrst ctl", {26'd0, ctl_now()}, 0);
    chk("midrst imm", id_imm, 0);
    chk("midrst stall", {31'd0, stall}, 0);
    @(negedge clk); rst_n = 1'b1;
    IF_ID = {32'h30, rtype(3,4,9,6'h20)}; if_valid = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    chk("post rst valid", {31'd0, id_valid}, 1);
    chk("post rst rs r3 cleared", id_rs_data, 0);
    chk("post rst rt r4 cleared", id_rt_data, 0);
    chk("post rst dest", {27'd0, id_dest}, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
